// File: rtl/npu_core_vec_if.sv
// Operand-beat and output-byte stream handshakes for npu_core_vec.
// Lane i of IN_A/IN_B occupies [i*DATA_W +: DATA_W].
interface npu_core_vec_if #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 8
);
    logic                        IN_VALID;
    logic                        IN_READY;
    logic                        IN_LAST;
    logic [NUM_LANES*DATA_W-1:0] IN_A;
    logic [NUM_LANES*DATA_W-1:0] IN_B;
    logic                        OUT_VALID;
    logic                        OUT_READY;
    logic [7:0]                  OUT_DATA;

    modport master (
        output IN_VALID, IN_LAST, IN_A, IN_B, OUT_READY,
        input  IN_READY, OUT_VALID, OUT_DATA
    );

    modport slave (
        input  IN_VALID, IN_LAST, IN_A, IN_B, OUT_READY,
        output IN_READY, OUT_VALID, OUT_DATA
    );
endinterface

// File: rtl/npu_core_vec.sv
// Sequenced NUM_LANES-wide signed MAC with bias, ReLU, running argmax and byte FIFO output.
// Define NPU_SAT_EN for saturating accumulation and a live OVF flag; otherwise adds wrap.
module npu_core_vec #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_W     = 8,
    parameter int ACC_W      = 16,
    parameter int FIFO_DEPTH = 128
) (
    input  logic                       CLKEXT,
    input  logic                       RST_N,
    npu_core_vec_if.slave              bus,
    input  logic [NUM_LANES*ACC_W-1:0] BIAS,
    input  logic [NUM_LANES-1:0]       BYPASS_RELU,
    input  logic                       CLR_ARGMAX,
    output logic [ACC_W-1:0]           LARGEST,
    output logic [7:0]                 INDEX,
    output logic                       ARGMAX_VALID,
    output logic                       BUSY,
    output logic                       OVF
);
    localparam int NBYTES = NUM_LANES * ACC_W / 8;
    localparam int SER_W  = $clog2(NBYTES) + 1;
    localparam int AW     = $clog2(FIFO_DEPTH);
`ifdef NPU_SAT_EN
    localparam int SUM_W  = ACC_W + 1;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int SUM_W  = ACC_W;
`endif

    typedef enum logic [1:0] {S_ACC, S_BIAS, S_ACT, S_SER} state_t;

    state_t state, state_nxt;

    logic                       in_fire;
    logic                       wr_en;
    logic                       rd_en;
    logic                       ser_last;
    logic [SER_W-1:0]           ser_idx;
    logic [7:0]                 ser_byte;

    logic signed [ACC_W-1:0]    acc     [NUM_LANES];
    logic signed [ACC_W-1:0]    acc_nxt [NUM_LANES];
    logic signed [ACC_W-1:0]    act     [NUM_LANES];
    logic [NUM_LANES*ACC_W-1:0] res;

    logic [DATA_W-1:0]          op_a, op_b;
    logic signed [ACC_W-1:0]    pa, pb, addend;
    logic [SUM_W-1:0]           sum;
`ifdef NPU_SAT_EN
    logic                       sat_hit;
    logic                       ovf_q;
`endif

    logic signed [ACC_W-1:0]    largest_q, best_val;
    logic [7:0]                 index_q, best_idx, cand_idx;
    logic                       valid_q, best_any;
    logic [7:0]                 group_cnt;

    logic [7:0]                 mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [AW:0]                count;
    logic                       fifo_full, fifo_empty;
    logic [7:0]                 head;

    // ---------------- sequencer ----------------
    always_ff @(posedge CLKEXT) begin
        if (!RST_N) state <= S_ACC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.IN_READY = 1'b0;
        wr_en        = 1'b0;
        ser_last     = 1'b0;
        unique case (state)
            S_ACC: begin
                bus.IN_READY = 1'b1;
                if (bus.IN_VALID && bus.IN_LAST) state_nxt = S_BIAS;
            end
            S_BIAS: state_nxt = S_ACT;
            S_ACT:  state_nxt = S_SER;
            S_SER: begin
                if (!fifo_full) begin
                    wr_en = 1'b1;
                    if (ser_idx == SER_W'(NBYTES - 1)) begin
                        ser_last  = 1'b1;
                        state_nxt = S_ACC;
                    end
                end
            end
            default: state_nxt = S_ACC;
        endcase
    end

    assign in_fire = bus.IN_VALID && bus.IN_READY;
    assign BUSY    = (state != S_ACC);

    // ---------------- lane datapath ----------------
    always_comb begin
        op_a   = '0;
        op_b   = '0;
        pa     = '0;
        pb     = '0;
        addend = '0;
        sum    = '0;
`ifdef NPU_SAT_EN
        sat_hit = 1'b0;
`endif
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            op_a   = bus.IN_A[i*DATA_W +: DATA_W];
            op_b   = bus.IN_B[i*DATA_W +: DATA_W];
            pa     = {{(ACC_W-DATA_W){op_a[DATA_W-1]}}, op_a};
            pb     = {{(ACC_W-DATA_W){op_b[DATA_W-1]}}, op_b};
            addend = '0;
            if (state == S_ACC && in_fire) addend = pa * pb;
            else if (state == S_BIAS)      addend = BIAS[i*ACC_W +: ACC_W];
`ifdef NPU_SAT_EN
            sum = {acc[i][ACC_W-1], acc[i]} + {addend[ACC_W-1], addend};
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc_nxt[i] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                sat_hit    = 1'b1;
            end else begin
                acc_nxt[i] = sum[ACC_W-1:0];
            end
`else
            sum        = acc[i] + addend;
            acc_nxt[i] = sum;
`endif
            if (ser_last) acc_nxt[i] = '0;
            act[i] = (acc[i][ACC_W-1] && !BYPASS_RELU[i]) ? '0 : acc[i];
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NUM_LANES; i++) acc[i] <= '0;
            res     <= '0;
            ser_idx <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_LANES; i++) acc[i] <= acc_nxt[i];
            if (state == S_ACT) begin
                for (int unsigned i = 0; i < NUM_LANES; i++) res[i*ACC_W +: ACC_W] <= act[i];
            end
            if (wr_en) ser_idx <= ser_last ? '0 : ser_idx + SER_W'(1);
        end
    end

`ifdef NPU_SAT_EN
    always_ff @(posedge CLKEXT) begin
        if (!RST_N || CLR_ARGMAX) ovf_q <= 1'b0;
        else if (sat_hit)         ovf_q <= 1'b1;
    end
    assign OVF = ovf_q;
`else
    assign OVF = 1'b0;
`endif

    // ---------------- running argmax ----------------
    // Strict > scan keeps the lowest lane on ties; an empty argmax takes lane 0 unconditionally.
    always_comb begin
        best_val = largest_q;
        best_idx = index_q;
        best_any = valid_q;
        cand_idx = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            cand_idx = 8'(32'(group_cnt) * NUM_LANES + i);
            if (!best_any || act[i] > best_val) begin
                best_val = act[i];
                best_idx = cand_idx;
                best_any = 1'b1;
            end
        end
    end

    always_ff @(posedge CLKEXT) begin
        if (!RST_N || CLR_ARGMAX) begin
            largest_q <= '0;
            index_q   <= '0;
            valid_q   <= 1'b0;
            group_cnt <= '0;
        end else if (state == S_ACT) begin
            largest_q <= best_val;
            index_q   <= best_idx;
            valid_q   <= 1'b1;
            group_cnt <= group_cnt + 8'd1;
        end
    end

    assign LARGEST      = largest_q;
    assign INDEX        = index_q;
    assign ARGMAX_VALID = valid_q;

    // ---------------- output byte FIFO ----------------
    always_comb begin
        ser_byte = '0;
        for (int unsigned j = 0; j < NBYTES; j++) begin
            if (ser_idx == SER_W'(j)) ser_byte = res[j*8 +: 8];
        end
    end

    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign rd_en      = bus.OUT_READY && !fifo_empty;

    always_ff @(posedge CLKEXT) begin
        if (wr_en) mem[wr_ptr] <= ser_byte;
    end

    // Head is a register so OUT_DATA only moves on a pop or on a write into an empty FIFO.
    always_ff @(posedge CLKEXT) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      count <= count + (AW+1)'(1);
            else if (rd_en && !wr_en) count <= count - (AW+1)'(1);
            if (rd_en) begin
                if (count > (AW+1)'(1)) head <= mem[rd_ptr + AW'(1)];
                else if (wr_en)         head <= ser_byte;
            end else if (wr_en && fifo_empty) begin
                head <= ser_byte;
            end
        end
    end

    assign bus.OUT_VALID = !fifo_empty;
    assign bus.OUT_DATA  = head;
endmodule

// File: tb/tb_npu_core_vec.sv
// Directed-vector bench for npu_core_vec (4 lanes, 8-bit operands, 16-bit accumulators, 8-byte FIFO).
module tb_npu_core_vec;
    localparam int NL = 4;
    localparam int DW = 8;
    localparam int AW = 16;
    localparam int FD = 8;
    localparam int NB = NL * AW / 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NL*AW-1:0] bias;
    logic [NL-1:0]   bypass_relu;
    logic            clr_argmax;
    logic [AW-1:0]   largest;
    logic [7:0]      index;
    logic            argmax_valid, busy, ovf;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0] rx [$];

    always #5 clk = ~clk;

    npu_core_vec_if #(.NUM_LANES(NL), .DATA_W(DW)) bus ();

    npu_core_vec #(
        .NUM_LANES (NL),
        .DATA_W    (DW),
        .ACC_W     (AW),
        .FIFO_DEPTH(FD)
    ) dut (
        .CLKEXT      (clk),
        .RST_N       (rst_n),
        .bus         (bus),
        .BIAS        (bias),
        .BYPASS_RELU (bypass_relu),
        .CLR_ARGMAX  (clr_argmax),
        .LARGEST     (largest),
        .INDEX       (index),
        .ARGMAX_VALID(argmax_valid),
        .BUSY        (busy),
        .OVF         (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] lanes8(input int l0, input int l1, input int l2, input int l3);
        return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        int unsigned t;
        t = 0;
        while (!bus.IN_READY && t < 200) begin
            tick();
            t++;
        end
        if (!bus.IN_READY) check("in_ready_timeout", bus.IN_READY, 1);
        bus.IN_A     = a;
        bus.IN_B     = b;
        bus.IN_LAST  = last;
        bus.IN_VALID = 1'b1;
        tick();
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
        bus.IN_A     = '0;
        bus.IN_B     = '0;
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while (busy && t < 300) begin
            tick();
            t++;
        end
        if (busy) check("idle_timeout", busy, 0);
    endtask

    task automatic drain(input int unsigned n);
        int unsigned t;
        rx.delete();
        bus.OUT_READY = 1'b1;
        for (int unsigned k = 0; k < n; k++) begin
            t = 0;
            while (!bus.OUT_VALID && t < 300) begin
                tick();
                t++;
            end
            if (!bus.OUT_VALID) begin
                check("out_valid_timeout", bus.OUT_VALID, 1);
                break;
            end
            rx.push_back(bus.OUT_DATA);
            tick();
        end
        bus.OUT_READY = 1'b0;
    endtask

    task automatic expect_group(input string tag, input logic [NL*AW-1:0] exp_res);
        drain(NB);
        check({tag, "_len"}, rx.size(), NB);
        for (int unsigned k = 0; k < NB; k++) begin
            if (k < rx.size()) check($sformatf("%s_b%0d", tag, k), rx[k], exp_res[k*8 +: 8]);
        end
    endtask

    task automatic pulse_clr();
        clr_argmax = 1'b1;
        tick();
        clr_argmax = 1'b0;
    endtask

    // lane0: 3*4 + 3*4 + bias 1 = 25; includes cycle-exact latency checks
    task automatic basic_mac(input string tag);
        bias        = {48'd0, 16'd1};
        bypass_relu = '0;
        beat(lanes8(3, 0, 0, 0), lanes8(4, 0, 0, 0), 1'b0);
        beat(lanes8(3, 0, 0, 0), lanes8(4, 0, 0, 0), 1'b1);
        check({tag, "_busy_k"}, busy, 1);
        check({tag, "_rdy_k"}, bus.IN_READY, 0);
        tick();
        check({tag, "_ov_k1"}, bus.OUT_VALID, 0);
        tick();
        check({tag, "_largest"}, largest, 25);
        check({tag, "_index"}, index, 0);
        check({tag, "_amvalid"}, argmax_valid, 1);
        check({tag, "_ov_k2"}, bus.OUT_VALID, 0);
        tick();
        check({tag, "_ov_k3"}, bus.OUT_VALID, 1);
        check({tag, "_head_k3"}, bus.OUT_DATA, 8'h19);
        repeat (NB - 2) tick();
        check({tag, "_rdy_last"}, bus.IN_READY, 0);
        tick();
        check({tag, "_rdy_after"}, bus.IN_READY, 1);
        check({tag, "_busy_after"}, busy, 0);
        expect_group(tag, {48'd0, 16'd25});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [16*8-1:0] exp_bp;

        rst_n         = 1'b0;
        bias          = '0;
        bypass_relu   = '0;
        clr_argmax    = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_LAST   = 1'b0;
        bus.IN_A      = '0;
        bus.IN_B      = '0;
        bus.OUT_READY = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;

        check("rst_in_ready", bus.IN_READY, 1);
        check("rst_out_valid", bus.OUT_VALID, 0);
        check("rst_out_data", bus.OUT_DATA, 0);
        check("rst_largest", largest, 0);
        check("rst_index", index, 0);
        check("rst_amvalid", argmax_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);

        basic_mac("mac");

        // ReLU clamps lane1 -10 to zero, bypass passes it through
        bias        = '0;
        bypass_relu = 4'b0000;
        beat(lanes8(0, -2, 0, 0), lanes8(0, 5, 0, 0), 1'b1);
        wait_idle();
        expect_group("relu", '0);
        bypass_relu = 4'b0010;
        beat(lanes8(0, -2, 0, 0), lanes8(0, 5, 0, 0), 1'b1);
        wait_idle();
        expect_group("bypass", {16'd0, 16'd0, 16'hFFF6, 16'd0});

        // 3 x 16129 = 48387 exceeds the 16-bit signed range
        bypass_relu = 4'b0001;
        beat(lanes8(127, 0, 0, 0), lanes8(127, 0, 0, 0), 1'b0);
        beat(lanes8(127, 0, 0, 0), lanes8(127, 0, 0, 0), 1'b0);
        beat(lanes8(127, 0, 0, 0), lanes8(127, 0, 0, 0), 1'b1);
        wait_idle();
`ifdef NPU_SAT_EN
        check("sat_ovf", ovf, 1);
        expect_group("sat", {48'd0, 16'h7FFF});
`else
        check("sat_ovf", ovf, 0);
        expect_group("sat", {48'd0, 16'hBD03});
`endif
        pulse_clr();
        check("sat_ovf_clr", ovf, 0);

        // argmax across groups
        bypass_relu = '0;
        pulse_clr();
        check("clr_amvalid", argmax_valid, 0);
        check("clr_largest", largest, 0);
        check("clr_index", index, 0);
        beat(lanes8(0, 0, 2, 0), lanes8(0, 0, 5, 0), 1'b1);
        wait_idle();
        check("g0_index", index, 2);
        check("g0_largest", largest, 10);
        expect_group("g0", {16'd0, 16'd10, 16'd0, 16'd0});
        beat(lanes8(0, 5, 0, 4), lanes8(0, 8, 0, 10), 1'b1);
        wait_idle();
        check("g1_index", index, 5);
        check("g1_largest", largest, 40);
        expect_group("g1", {16'd40, 16'd0, 16'd40, 16'd0});
        beat(lanes8(8, 0, 0, 0), lanes8(5, 0, 0, 0), 1'b1);
        wait_idle();
        check("g2_index", index, 5);
        check("g2_largest", largest, 40);
        drain(NB);
        beat(lanes8(0, 0, 5, 0), lanes8(0, 0, 10, 0), 1'b1);
        wait_idle();
        check("g3_index", index, 14);
        check("g3_largest", largest, 50);
        drain(NB);
        pulse_clr();
        check("clr2_amvalid", argmax_valid, 0);
        check("clr2_index", index, 0);
        check("clr2_largest", largest, 0);

        // first group after a clear loads even when every lane is negative
        bypass_relu = 4'b1111;
        beat(lanes8(-1, -1, -1, -1), lanes8(5, 2, 2, 7), 1'b1);
        wait_idle();
        check("neg_index", index, 1);
        check("neg_largest", largest, 16'hFFFE);
        drain(NB);
        bypass_relu = '0;
        pulse_clr();

        // back-pressure: first group fills the FIFO, second stalls in serialisation
        beat(lanes8(1, 2, 3, 4), lanes8(1, 1, 1, 1), 1'b1);
        wait_idle();
        check("bp_ov_full", bus.OUT_VALID, 1);
        beat(lanes8(5, 6, 7, 8), lanes8(1, 1, 1, 1), 1'b1);
        repeat (15) tick();
        check("bp_busy_stall", busy, 1);
        check("bp_rdy_stall", bus.IN_READY, 0);
        check("bp_head", bus.OUT_DATA, 8'h01);
        drain(16);
        exp_bp = {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
        check("bp_len", rx.size(), 16);
        for (int unsigned k = 0; k < 16; k++) begin
            if (k < rx.size()) check($sformatf("bp_b%0d", k), rx[k], exp_bp[k*8 +: 8]);
        end
        check("bp_ov_empty", bus.OUT_VALID, 0);
        check("bp_busy_done", busy, 0);

        // reset on the edge that would write byte 3
        bias = {48'd0, 16'd1};
        beat(lanes8(3, 0, 0, 0), lanes8(4, 0, 0, 0), 1'b0);
        beat(lanes8(3, 0, 0, 0), lanes8(4, 0, 0, 0), 1'b1);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_out_valid", bus.OUT_VALID, 0);
        check("mrst_busy", busy, 0);
        check("mrst_largest", largest, 0);
        check("mrst_amvalid", argmax_valid, 0);
        check("mrst_in_ready", bus.IN_READY, 1);
        basic_mac("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/npu_core_vec.md
# npu_core_vec

Parametrised successor to the fixed two-MAC NPU datapath. It runs NUM_LANES signed MAC lanes in parallel, each with saturating accumulation, per-lane bias and per-lane ReLU bypass. It keeps a running argmax across successive lane groups and serialises results LSB-first into an output byte FIFO with valid/ready handshakes. The whole flow is driven by an internal sequencer instead of per-cycle external control words.

## Interface
- NUM_LANES, 4, parallel MAC lanes (1..16)
- DATA_W, 8, signed operand width
- ACC_W, 16, signed accumulator width; multiple of 8 and ≥ 2*DATA_W
- FIFO_DEPTH, 128, output FIFO depth in bytes; power of 2
- CLKEXT  in  1  clock, all logic on rising edge
- RST_N  in  1  synchronous, active-low reset
- IN_VALID  in  1  operand beat valid
- IN_READY  out  1  beat accepted when IN_VALID & IN_READY
- IN_LAST  in  1  marks the final beat of a dot product
- IN_A, IN_B  in  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W], signed
- BIAS  in  NUM_LANES*ACC_W  per-lane bias, sampled in S_BIAS
- BYPASS_RELU  in  NUM_LANES  1 = pass lane result unmodified
- CLR_ARGMAX  in  1  clears LARGEST, INDEX, ARGMAX_VALID and the group counter
- OUT_VALID  out  1  FIFO not empty
- OUT_READY  in  1  pop when OUT_VALID & OUT_READY
- OUT_DATA  out  8  FIFO head, first-word-fall-through
- LARGEST  out  ACC_W  running maximum post-activation value
- INDEX  out  8  group*NUM_LANES + lane of LARGEST, mod 256
- ARGMAX_VALID  out  1  at least one group compared since clear or reset
- BUSY  out  1  FSM not in S_ACC
- OVF  out  1  sticky saturation flag

## Operation
- FSM states: S_ACC → S_BIAS → S_ACT → S_SER → S_ACC.
- **S_ACC** (IN_READY=1):
  - Each accepted beat does acc[i] += a[i]*b[i]. The product is a full 2*DATA_W signed value, sign-extended to ACC_W.
  - A beat with IN_LAST moves the FSM to S_BIAS.
  - Accumulators start at 0 after reset and after each S_SER.
- **S_BIAS**: acc[i] += BIAS[i], one cycle.
- **S_ACT**, one cycle:
  - res[i] = (acc[i] < 0 && !BYPASS_RELU[i]) ? 0 : acc[i], registered.
  - Argmax update, signed compare: lanes are scanned 0..N-1 and a lane replaces the current max only if strictly greater, so the lowest index wins ties.
  - The first group after a clear always loads.
  - The group counter increments.
- **S_SER**:
  - Writes NUM_LANES*ACC_W/8 bytes in order: lane 0 LSB first, then lane 1, and so on. One byte per cycle, only when the FIFO is not full; otherwise the FSM holds the byte and stalls.
  - After the last byte, accumulators clear and the FSM enters S_ACC.
- **Saturation**: with NPU_SAT_EN, every accumulator add (MAC and bias) clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1] and sets OVF.
- **FIFO**:
  - Full is based on the registered count, so a write is blocked when full even if a pop happens in the same cycle.
  - A simultaneous pop and write when not full leaves the count unchanged.
  - A pop when empty is ignored.
- **CLR_ARGMAX**:
  - Has priority over the S_ACT argmax update; that group's update is discarded.
  - The group counter still resets to 0.
  - Clears OVF.
- **Reset**:
  - RST_N low at an edge returns the FSM to S_ACC and clears accumulators, res, FIFO pointers and count, the argmax state and OVF.
  - Reset values of outputs: IN_READY=1 (once in S_ACC), OUT_VALID=0, OUT_DATA=0, LARGEST=0, INDEX=0, ARGMAX_VALID=0, BUSY=0, OVF=0.
  - Reset mid-S_SER discards the remaining bytes.

## Timing
- IN_LAST is accepted at edge k.
- Bias is added at edge k+1, and res/argmax are registered at edge k+2.
- The first FIFO write happens at edge k+3, and OUT_VALID is high after edge k+3.
- LARGEST and INDEX are valid after edge k+2.
- IN_READY is low from edge k through the edge that writes the last byte. With no stall it rises after edge k+2+NUM_LANES*ACC_W/8.
- OUT_DATA changes only on a pop or on a write into an empty FIFO.

## Configuration
- NPU_SAT_EN:
  - Defined: saturating accumulation, and OVF is a functional sticky flag.
  - Undefined: two's-complement wrap, and OVF is tied to 0.

## Test plan
- **Basic MAC**: lane0 beats (3,4),(3,4)+LAST, bias0=1, other lanes 0 → first bytes 0x19,0x00, then six 0x00; LARGEST=25, INDEX=0.
- **ReLU and bypass**: lane1 (−2,5)+LAST with BYPASS_RELU=0 → bytes 0x00,0x00; repeated with BYPASS_RELU[1]=1 → 0xF6,0xFF.
- **Saturation**: lane0 (127,127) ×3 beats → with NPU_SAT_EN: 0x7FFF and OVF=1. Without NPU_SAT_EN: 0xBD03 and OVF=0.
- **Argmax over groups**:
  - Group 0 lane2=10; group 1 lane3=40 and lane1=40 → INDEX=5.
  - Group 2 max 40 → INDEX stays 5.
  - CLR_ARGMAX → ARGMAX_VALID=0.
- **Back-pressure**: FIFO_DEPTH=8, OUT_READY=0, two groups → the first fills the FIFO and the second stalls in S_SER with IN_READY=0. Then OUT_READY=1 → all 16 bytes drain in order with none lost or duplicated.
- **Reset mid-serialise**: RST_N low for 1 cycle during S_SER byte 3 → OUT_VALID=0, BUSY=0, LARGEST=0. A new group then behaves as in the basic MAC case.
